// File: rtl/mem_port_arbiter_if.sv
// Bundle of request, grant, completion and main-memory signals around mem_port_arbiter.
// master is the arbiter side; slave is the caches plus the memory model.
interface mem_port_arbiter_if;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_gnt;
  logic         i_done;
  logic [255:0] i_line;

  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [31:0]  d_wdata;
  logic         d_gnt;
  logic         d_done;
  logic [255:0] d_line;

  logic         err;

  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ce_n;
  logic         mem_we_n;
  logic         mem_oe_n;
  logic         mem_multiple_read;
  logic [255:0] mem_line;
  logic         mem_read_full;
  logic         mem_hold;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_line, mem_read_full, mem_hold,
    output i_gnt, i_done, i_line, d_gnt, d_done, d_line, err,
           mem_addr, mem_wdata, mem_ce_n, mem_we_n, mem_oe_n, mem_multiple_read
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_line, mem_read_full, mem_hold,
    input  i_gnt, i_done, i_line, d_gnt, d_done, d_line, err,
           mem_addr, mem_wdata, mem_ce_n, mem_we_n, mem_oe_n, mem_multiple_read
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache refills and D-cache accesses.
// Every output is registered and reflects the state the FSM is currently in.
module mem_port_arbiter #(
  parameter logic [31:0] START_ADRESS   = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic               owner_d;
  logic               last_owner_d;
  logic               we_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               grant_d;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [31:0]        aligned_addr;
  logic               illegal;
  logic               complete;

  // On a tie the requester that did not own the port last time wins.
  always_comb begin
    grant_d      = bus.d_req && (!bus.i_req || !last_owner_d);
    sel_we       = grant_d && bus.d_we;
    sel_addr     = grant_d ? bus.d_addr : bus.i_addr;
    aligned_addr = sel_we ? {sel_addr[31:2], 2'b00} : {sel_addr[31:5], 5'b0};
    illegal      = sel_addr < START_ADRESS;
    complete     = we_q ? !bus.mem_hold : bus.mem_read_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      owner_d               <= 1'b0;
      last_owner_d          <= 1'b1;
      we_q                  <= 1'b0;
      wait_cnt              <= '0;
      bus.i_gnt             <= 1'b0;
      bus.i_done            <= 1'b0;
      bus.i_line            <= '0;
      bus.d_gnt             <= 1'b0;
      bus.d_done            <= 1'b0;
      bus.d_line            <= '0;
      bus.err               <= 1'b0;
      bus.mem_addr          <= '0;
      bus.mem_wdata         <= '0;
      bus.mem_ce_n          <= 1'b1;
      bus.mem_we_n          <= 1'b1;
      bus.mem_oe_n          <= 1'b1;
      bus.mem_multiple_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            owner_d   <= grant_d;
            we_q      <= sel_we;
            bus.i_gnt <= !grant_d;
            bus.d_gnt <= grant_d;
            if (illegal) begin
              // Rejected addresses never touch the memory strobes.
              state      <= DONE;
              bus.err    <= 1'b1;
              bus.i_done <= !grant_d;
              bus.d_done <= grant_d;
            end else begin
              state                 <= ISSUE;
              bus.mem_addr          <= aligned_addr;
              bus.mem_wdata         <= grant_d ? bus.d_wdata : 32'h0;
              bus.mem_ce_n          <= 1'b0;
              bus.mem_oe_n          <= sel_we;
              bus.mem_we_n          <= !sel_we;
              bus.mem_multiple_read <= !sel_we;
            end
          end
        end

        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (complete || wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (complete && !we_q) begin
              if (owner_d) bus.d_line <= bus.mem_line;
              else         bus.i_line <= bus.mem_line;
            end
            state                 <= DONE;
            bus.err               <= !complete;
            bus.i_done            <= !owner_d;
            bus.d_done            <= owner_d;
            bus.mem_ce_n          <= 1'b1;
            bus.mem_we_n          <= 1'b1;
            bus.mem_oe_n          <= 1'b1;
            bus.mem_multiple_read <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state        <= IDLE;
          last_owner_d <= owner_d;
          bus.i_gnt    <= 1'b0;
          bus.d_gnt    <= 1'b0;
          bus.i_done   <= 1'b0;
          bus.d_done   <= 1'b0;
          bus.err      <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a D-side vector table plus hand sequences for
// arbitration, long reads, timeout and mid-transaction reset.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus8 ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_hold;
    logic        exp_d_gnt;
    logic        exp_d_done;
    logic        exp_err;
    logic        exp_ce_n;
    logic        exp_we_n;
    logic        exp_oe_n;
    logic        exp_mr;
    logic        chk_addr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [8];

  logic [255:0] line_a, line_b, line_c, line_d, line_e;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectGnt(input string tag, input logic ei, input logic ed);
    checkVal({tag, ".i_gnt"}, bus.i_gnt, ei);
    checkVal({tag, ".d_gnt"}, bus.d_gnt, ed);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.i_req         = 1'b0;
    bus.d_req         = v.d_req;
    bus.d_we          = v.d_we;
    bus.d_addr        = v.d_addr;
    bus.d_wdata       = v.d_wdata;
    bus.mem_hold      = v.mem_hold;
    bus.mem_read_full = 1'b0;
    step();
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    expectGnt(t, 1'b0, v.exp_d_gnt);
    checkVal({t, ".d_done"}, bus.d_done, v.exp_d_done);
    checkVal({t, ".i_done"}, bus.i_done, 1'b0);
    checkVal({t, ".err"}, bus.err, v.exp_err);
    checkVal({t, ".ce_n"}, bus.mem_ce_n, v.exp_ce_n);
    checkVal({t, ".we_n"}, bus.mem_we_n, v.exp_we_n);
    checkVal({t, ".oe_n"}, bus.mem_oe_n, v.exp_oe_n);
    checkVal({t, ".mr"}, bus.mem_multiple_read, v.exp_mr);
    if (v.chk_addr) begin
      checkVal({t, ".mem_addr"}, bus.mem_addr, v.exp_addr);
      checkVal({t, ".mem_wdata"}, bus.mem_wdata, 32'hDEADBEEF);
    end
  endtask

  task automatic setVec(input int idx, input logic req, input logic we, input logic [31:0] addr,
                        input logic hold, input logic eg, input logic edn, input logic ee,
                        input logic ce, input logic wen, input logic oe, input logic mr,
                        input logic ca, input logic [31:0] ea);
    vecs[idx].d_req      = req;
    vecs[idx].d_we       = we;
    vecs[idx].d_addr     = addr;
    vecs[idx].d_wdata    = 32'hDEADBEEF;
    vecs[idx].mem_hold   = hold;
    vecs[idx].exp_d_gnt  = eg;
    vecs[idx].exp_d_done = edn;
    vecs[idx].exp_err    = ee;
    vecs[idx].exp_ce_n   = ce;
    vecs[idx].exp_we_n   = wen;
    vecs[idx].exp_oe_n   = oe;
    vecs[idx].exp_mr     = mr;
    vecs[idx].chk_addr   = ca;
    vecs[idx].exp_addr   = ea;
  endtask

  initial begin
    line_a = {8{32'hA5A5_0001}};
    line_b = {8{32'hB6B6_0002}};
    line_c = {8{32'hC7C7_0003}};
    line_d = {8{32'hD8D8_0004}};
    line_e = {4{64'h0123_4567_89AB_CDEF}};

    // D write with two busy cycles, then an illegal-address read.
    setVec(0, 1, 1, 32'h0040_0106, 1, 1, 0, 0, 0, 0, 1, 0, 1, 32'h0040_0104);
    setVec(1, 1, 1, 32'h0040_0106, 1, 1, 0, 0, 0, 0, 1, 0, 1, 32'h0040_0104);
    setVec(2, 1, 1, 32'h0040_0106, 1, 1, 0, 0, 0, 0, 1, 0, 1, 32'h0040_0104);
    setVec(3, 1, 1, 32'h0040_0106, 0, 1, 1, 0, 1, 1, 1, 0, 0, 32'h0);
    setVec(4, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h0);
    setVec(5, 1, 0, 32'h0000_0010, 0, 1, 1, 1, 1, 1, 1, 0, 0, 32'h0);
    setVec(6, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h0);
    setVec(7, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h0);

    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.mem_line = 0; bus.mem_read_full = 0; bus.mem_hold = 0;
    bus8.i_req = 0; bus8.i_addr = 0; bus8.d_req = 0; bus8.d_we = 0; bus8.d_addr = 0; bus8.d_wdata = 0;
    bus8.mem_line = 0; bus8.mem_read_full = 0; bus8.mem_hold = 0;

    reset = 1'b1;
    step();
    step();
    expectGnt("rst", 1'b0, 1'b0);
    checkVal("rst.ce_n", bus.mem_ce_n, 1'b1);
    checkVal("rst.oe_n", bus.mem_oe_n, 1'b1);
    checkVal("rst.we_n", bus.mem_we_n, 1'b1);
    checkVal("rst.mr", bus.mem_multiple_read, 1'b0);
    checkVal("rst.mem_addr", bus.mem_addr, 32'h0);
    checkVal("rst.done", {bus.i_done, bus.d_done, bus.err}, 3'b000);
    reset = 1'b0;
    step();

    // Simultaneous requests right after reset: I first, then alternation while I keeps asking.
    bus.i_req = 1; bus.i_addr = 32'h0040_0040;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0040_0084;
    step();
    expectGnt("arb1", 1'b1, 1'b0);
    checkVal("arb1.mem_addr", bus.mem_addr, 32'h0040_0040);
    step();
    bus.mem_read_full = 1; bus.mem_line = line_a;
    step();
    checkVal("arb1.i_done", bus.i_done, 1'b1);
    checkVal("arb1.d_done", bus.d_done, 1'b0);
    checkVal("arb1.i_line", bus.i_line, line_a);
    bus.mem_read_full = 0;
    step();
    expectGnt("arb1.idle", 1'b0, 1'b0);
    step();
    expectGnt("arb2", 1'b0, 1'b1);
    checkVal("arb2.mem_addr", bus.mem_addr, 32'h0040_0080);
    step();
    bus.mem_read_full = 1; bus.mem_line = line_b;
    step();
    checkVal("arb2.d_done", bus.d_done, 1'b1);
    checkVal("arb2.d_line", bus.d_line, line_b);
    checkVal("arb2.i_line", bus.i_line, line_a);
    bus.mem_read_full = 0; bus.d_req = 0;
    step();
    step();
    expectGnt("arb3", 1'b1, 1'b0);
    step();
    bus.mem_read_full = 1; bus.mem_line = line_c;
    step();
    checkVal("arb3.i_done", bus.i_done, 1'b1);
    checkVal("arb3.i_line", bus.i_line, line_c);
    bus.mem_read_full = 0; bus.i_req = 0;
    step();
    expectGnt("arb3.idle", 1'b0, 1'b0);

    // I line read with fifteen WAIT cycles before the line arrives.
    bus.i_req = 1; bus.i_addr = 32'h0040_0024;
    step();
    expectGnt("rd", 1'b1, 1'b0);
    checkVal("rd.mem_addr", bus.mem_addr, 32'h0040_0020);
    checkVal("rd.mr", bus.mem_multiple_read, 1'b1);
    checkVal("rd.strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b001);
    step();
    for (int k = 0; k < 15; k++) begin
      step();
      checkVal($sformatf("rd.wait%0d.i_done", k), bus.i_done, 1'b0);
    end
    bus.mem_read_full = 1; bus.mem_line = line_d;
    step();
    checkVal("rd.i_done", bus.i_done, 1'b1);
    checkVal("rd.err", bus.err, 1'b0);
    checkVal("rd.i_line", bus.i_line, line_d);
    checkVal("rd.ce_n", bus.mem_ce_n, 1'b1);
    bus.mem_read_full = 0; bus.i_req = 0;
    step();
    checkVal("rd.idle.i_done", bus.i_done, 1'b0);
    checkVal("rd.idle.i_line", bus.i_line, line_d);

    // Table-driven D write and illegal address.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v]);
      checkOutput(v, vecs[v]);
    end
    checkVal("wr.d_line", bus.d_line, line_b);

    // Timeout on the short-timeout instance.
    bus8.i_req = 1; bus8.i_addr = 32'h0040_0000;
    step();
    checkVal("to.i_gnt", bus8.i_gnt, 1'b1);
    step();
    for (int k = 0; k < 7; k++) begin
      step();
      checkVal($sformatf("to.wait%0d.i_done", k), bus8.i_done, 1'b0);
    end
    step();
    checkVal("to.i_done", bus8.i_done, 1'b1);
    checkVal("to.err", bus8.err, 1'b1);
    checkVal("to.strobes", {bus8.mem_ce_n, bus8.mem_oe_n, bus8.mem_we_n, bus8.mem_multiple_read}, 4'b1110);
    checkVal("to.i_line", bus8.i_line, 256'h0);
    bus8.i_req = 0;
    step();
    checkVal("to.idle.err", bus8.err, 1'b0);

    // Reset while waiting on memory, with the request still pending.
    bus.i_req = 1; bus.i_addr = 32'h0040_0100;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    expectGnt("mrst", 1'b0, 1'b0);
    checkVal("mrst.done", {bus.i_done, bus.d_done, bus.err}, 3'b000);
    checkVal("mrst.strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_multiple_read}, 4'b1110);
    checkVal("mrst.mem_addr", bus.mem_addr, 32'h0);
    checkVal("mrst.i_line", bus.i_line, 256'h0);
    reset = 1'b0;
    step();
    expectGnt("mrst.regrant", 1'b1, 1'b0);
    checkVal("mrst.mem_addr2", bus.mem_addr, 32'h0040_0100);
    step();
    bus.mem_read_full = 1; bus.mem_line = line_e;
    step();
    checkVal("mrst.i_done", bus.i_done, 1'b1);
    checkVal("mrst.i_line2", bus.i_line, line_e);
    bus.mem_read_full = 0; bus.i_req = 0;
    step();
    expectGnt("mrst.idle", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk) begin
    if (bus.i_gnt && bus.d_gnt) begin
      checks++;
      errors++;
      $display("[TB] FAIL gnt_exclusive: i_gnt=%0b d_gnt=%0b required not both", bus.i_gnt, bus.d_gnt);
    end
  end

endmodule
